instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Fetch stage of the MIPS-lite core, placed directly upstream of the opcode decoder. It owns the program counter and fetches one instruction at a time over a req/ack handshake with instruction memory. It holds the fetched word and presents its opcode field to the decoder. When the datapath retires the instruction, it computes the next PC (sequential, taken branch, or jump) from the held instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc, so [1:0] is always 2'b00.
- imem_rdata  in  32  instruction word; valid only in a cycle with imem_ack=1.
- imem_ack  in  1  memory completion strobe.
- instr  out  32  held instruction word.
- op  out  6  instr[31:26]; feeds the decoder opcode input.
- pc  out  32  address of the held or fetching instruction.
- pc_plus4  out  32  pc+4; used as the JAL link value.
- instr_valid  out  1  instr/op are valid and awaiting retire.
- retire  in  1  datapath completes the held instruction this cycle.
- branch_taken  in  1  Branch qualified by ALU zero; sampled with retire.
- jmp  in  1  jump control; sampled with retire.
- retired_count  out  32  number of retired instructions; wraps.

## Operation
- FSM has three states: IDLE (the reset state), REQ, and VALID.
  - IDLE -> REQ unconditionally at the first edge after reset.
  - REQ -> VALID on an edge where imem_ack=1. On that edge: instr <= imem_rdata. REQ is held while imem_ack=0.
  - VALID -> REQ on an edge where retire=1. On that edge: pc <= next_pc and retired_count <= retired_count+1. VALID is held while retire=0.
- Moore outputs: imem_req = (state==REQ); instr_valid = (state==VALID).
- next_pc:
  - jmp=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch_taken=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: pc_plus4.
  - jmp takes priority over branch_taken.
- Arithmetic is 32-bit modulo 2^32. PC wrap past 32'hFFFF_FFFC is not flagged.
- retire, jmp, and branch_taken are ignored outside VALID.
- imem_ack outside REQ is ignored; rdata is not captured and the state does not change.
- retired_count wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset values, applied asynchronously with no clock required:
  - state = IDLE, pc = RESET_PC, instr = 0, op = 0.
  - imem_req = 0, instr_valid = 0, retired_count = 0.
  - pc_plus4 = RESET_PC+4.
- imem_req first rises in the cycle after the first post-reset edge.
- imem_addr and imem_req are stable from entering REQ until the ack edge. Memory may hold off ack any number of cycles.
- Ack may arrive in the first REQ cycle, so minimum fetch latency is 1 cycle (REQ to VALID).
- Minimum throughput is one instruction per 2 cycles (REQ, VALID alternating).
- instr, op, pc, and pc_plus4 are constant throughout VALID. The decoder sees op combinationally from the instr register.
- rst asserted mid-REQ abandons the fetch. An ack arriving after release in IDLE is ignored, and the next REQ cycle re-requests RESET_PC.
- rst asserted in VALID discards the held instruction; retired_count is not incremented.

## Test plan
- Reset: hold rst=1 -> pc=0x3000, imem_req=0, instr_valid=0, retired_count=0. Release rst -> after one edge, imem_req=1 and imem_addr=0x3000.
- Zero-wait sequential fetch: ack in the first REQ cycle with rdata=0x3401_0005 -> next cycle instr_valid=1, op=6'b001101, pc_plus4=0x3004. Pulse retire -> imem_addr=0x3004 and retired_count=1.
- Taken branch: instr 0x1000_FFFF at pc 0x3004; retire with branch_taken=1 -> next imem_addr=0x3004. Same instruction with branch_taken=0 -> 0x3008.
- Jump priority: instr 0x0C00_0C10 at pc 0x3008; retire with jmp=1 and branch_taken=1 -> next imem_addr=0x3040.
- Wait states: delay ack 3 cycles -> imem_req=1 and addr stable for 4 cycles, instr_valid=0. retire pulsed during REQ -> pc and retired_count unchanged. A stray ack pulsed during VALID -> instr unchanged.
- Async reset mid-fetch: assert rst between edges during REQ -> imem_req=0 and pc=0x3000 immediately, before the next clock edge. Ack after release while in IDLE -> ignored; fetch restarts at 0x3000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over req/ack, holds the
// instruction for the decoder and advances the PC on retire.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        branch_taken,
    input  logic        jmp,
    output logic [31:0] retired_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]  state;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign op          = instr[31:26];
    assign imem_req    = (state == REQ);
    assign instr_valid = (state == VALID);

    // Jump outranks a taken branch.
    always_comb begin
        br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc = pc_plus4;
        if (jmp) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr         <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (retire) begin
                        pc            <= next_pc;
                        retired_count <= retired_count + 32'd1;
                        state         <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
